// File: rtl/ram_req_arbiter.sv
// ram_req_arbiter
//   Shares the single RAM port among NCPU cores. Each core has an instruction
//   requester and a data requester. Data requests take priority over fetches.
//   Within each class, a round-robin pointer rotates between the cores. A
//   starvation counter forces a fetch grant when instruction requests have
//   been pending for too long.
//
//   Ports:
//     CLK, nRST          clock (rising edge), synchronous active-low reset
//     iREN/iaddr         per-core instruction read request and address
//     dREN/dWEN          per-core data read/write request (both set = write)
//     daddr/dstore       per-core data address and write data
//     ramstate           RAM status: FREE=0 BUSY=1 ACCESS=2 ERROR=3
//     ramREN/ramWEN      RAM enables, driven live from the current owner
//     ramaddr/ramstore   RAM address and write data
//     iwait/dwait        per-core wait; 0 for the owner in its ACCESS cycle
//     gnt_valid/core/data  current owner (valid, core index, 1 = data)
module ram_req_arbiter #(
    parameter int NCPU         = 2,
    parameter int WORD_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [NCPU-1:0]          iREN,
    input  logic [NCPU*WORD_W-1:0]   iaddr,
    input  logic [NCPU-1:0]          dREN,
    input  logic [NCPU-1:0]          dWEN,
    input  logic [NCPU*WORD_W-1:0]   daddr,
    input  logic [NCPU*WORD_W-1:0]   dstore,
    input  logic [1:0]               ramstate,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [WORD_W-1:0]        ramaddr,
    output logic [WORD_W-1:0]        ramstore,
    output logic [NCPU-1:0]          iwait,
    output logic [NCPU-1:0]          dwait,
    output logic                     gnt_valid,
    output logic [$clog2(NCPU)-1:0]  gnt_core,
    output logic                     gnt_data
);

    localparam int CW = $clog2(NCPU);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [0:0]    IDLE = 1'b0;
    localparam logic [0:0]    OWN  = 1'b1;
    localparam logic [1:0]    RAM_ACCESS = 2'd2;
    localparam logic [CW-1:0] LAST = CW'(NCPU - 1);
    localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

    logic [0:0]      state;
    logic [CW-1:0]   own_core;
    logic            own_data;
    logic [CW-1:0]   rr_d;
    logic [CW-1:0]   rr_i;
    logic [SW-1:0]   starve;

    logic [NCPU-1:0] dreq;
    logic [NCPU-1:0] ireq;
    logic            any_d;
    logic            any_i;
    logic            pick_d;
    logic            fetch_gnt;
    logic [CW-1:0]   win;

    logic              sel_iren;
    logic              sel_dren;
    logic              sel_dwen;
    logic [WORD_W-1:0] sel_iaddr;
    logic [WORD_W-1:0] sel_daddr;
    logic [WORD_W-1:0] sel_dstore;
    logic              own_req;
    logic              done;

    // Pointers wrap by comparing against the last core index, so any NCPU works.
    function automatic logic [CW-1:0] rr_next(input logic [CW-1:0] c);
        return (c == LAST) ? '0 : c + CW'(1);
    endfunction

    // First requester at or after ptr, scanning with wrap-around.
    function automatic logic [CW-1:0] rr_pick(input logic [NCPU-1:0] req,
                                              input logic [CW-1:0]   ptr);
        logic [CW-1:0] idx;
        logic [CW-1:0] sel;
        logic          found;
        idx   = ptr;
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < NCPU; k++) begin
            if (!found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
            idx = rr_next(idx);
        end
        return sel;
    endfunction

    assign dreq  = dREN | dWEN;
    assign ireq  = iREN;
    assign any_d = |dreq;
    assign any_i = |ireq;

    // The data class wins unless a saturated starvation count forces a fetch.
    assign pick_d    = any_d && !((starve == SLIM) && any_i);
    assign win       = pick_d ? rr_pick(dreq, rr_d) : rr_pick(ireq, rr_i);
    assign fetch_gnt = (state == IDLE) && any_i && !pick_d;

    // Owner's live inputs.
    always_comb begin
        sel_iren   = 1'b0;
        sel_dren   = 1'b0;
        sel_dwen   = 1'b0;
        sel_iaddr  = '0;
        sel_daddr  = '0;
        sel_dstore = '0;
        for (int c = 0; c < NCPU; c++) begin
            if (own_core == CW'(c)) begin
                sel_iren   = iREN[c];
                sel_dren   = dREN[c];
                sel_dwen   = dWEN[c];
                sel_iaddr  = iaddr[c*WORD_W +: WORD_W];
                sel_daddr  = daddr[c*WORD_W +: WORD_W];
                sel_dstore = dstore[c*WORD_W +: WORD_W];
            end
        end
    end

    assign own_req = own_data ? (sel_dren | sel_dwen) : sel_iren;
    // A withdrawn request never completes, even if ACCESS shows up that cycle.
    assign done    = (state == OWN) && own_req && (ramstate == RAM_ACCESS);

    always_comb begin
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        gnt_valid = 1'b0;
        gnt_core  = '0;
        gnt_data  = 1'b0;
        iwait     = '1;
        dwait     = '1;
        if (state == OWN) begin
            gnt_valid = 1'b1;
            gnt_core  = own_core;
            gnt_data  = own_data;
            if (own_data) begin
                ramWEN  = sel_dwen;
                ramREN  = sel_dren && !sel_dwen;
                ramaddr = sel_daddr;
                if (sel_dwen)
                    ramstore = sel_dstore;
            end else begin
                ramREN  = sel_iren;
                ramaddr = sel_iaddr;
            end
        end
        for (int c = 0; c < NCPU; c++) begin
            if (done && own_core == CW'(c)) begin
                if (own_data)
                    dwait[c] = 1'b0;
                else
                    iwait[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state    <= IDLE;
            own_core <= '0;
            own_data <= 1'b0;
            rr_d     <= '0;
            rr_i     <= '0;
            starve   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_d || any_i) begin
                        state    <= OWN;
                        own_core <= win;
                        own_data <= pick_d;
                        if (pick_d)
                            rr_d <= rr_next(win);
                        else
                            rr_i <= rr_next(win);
                    end
                end
                default: begin
                    // ERROR and BUSY simply hold ownership.
                    if (!own_req || ramstate == RAM_ACCESS)
                        state <= IDLE;
                end
            endcase

            if (fetch_gnt)
                starve <= '0;
            else if (any_i && starve != SLIM)
                starve <= starve + SW'(1);
        end
    end

endmodule

// File: tb/tb_ram_req_arbiter.sv
// Directed bench for ram_req_arbiter (NCPU=2, WORD_W=32, STARVE_LIMIT=8).
// Inputs change 1 time unit after each rising edge and outputs are sampled
// on the falling edge. Expected values are hand-derived cycle by cycle.
module tb_ram_req_arbiter;

    logic        CLK;
    logic        nRST;
    logic [1:0]  iREN;
    logic [63:0] iaddr;
    logic [1:0]  dREN;
    logic [1:0]  dWEN;
    logic [63:0] daddr;
    logic [63:0] dstore;
    logic [1:0]  ramstate;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [1:0]  iwait;
    logic [1:0]  dwait;
    logic        gnt_valid;
    logic [0:0]  gnt_core;
    logic        gnt_data;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2;

    ram_req_arbiter #(.NCPU(2), .WORD_W(32), .STARVE_LIMIT(8)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN),
        .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .ramstate(ramstate),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .iwait(iwait), .dwait(dwait), .gnt_valid(gnt_valid), .gnt_core(gnt_core),
        .gnt_data(gnt_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge CLK);
        #1;
    endtask

    task automatic smp;
        @(negedge CLK);
    endtask

    task automatic idle_inputs;
        iREN = '0; dREN = '0; dWEN = '0; ramstate = FREE;
    endtask

    initial begin
        nRST = 1'b0;
        iREN = 2'b11; dREN = 2'b11; dWEN = 2'b11; ramstate = BUSY;
        iaddr = '0; daddr = '0; dstore = '0;

        // Reset held for two edges with every request asserted.
        cyc; cyc; smp;
        chk("rst_ramREN", ramREN, 0);
        chk("rst_ramWEN", ramWEN, 0);
        chk("rst_iwait", iwait, 2'b11);
        chk("rst_dwait", dwait, 2'b11);
        chk("rst_gnt_valid", gnt_valid, 0);
        chk("rst_ramaddr", ramaddr, 0);
        cyc; idle_inputs;
        cyc; nRST = 1'b1;

        // Single fetch from core 0; ACCESS in the third owned cycle.
        cyc; iREN = 2'b01; iaddr[31:0] = 32'h40; smp;
        chk("f_t0_ramREN", ramREN, 0);
        chk("f_t0_gnt_valid", gnt_valid, 0);
        cyc; ramstate = BUSY; smp;
        chk("f_t1_ramREN", ramREN, 1);
        chk("f_t1_ramaddr", ramaddr, 32'h40);
        chk("f_t1_iwait", iwait, 2'b11);
        chk("f_t1_gnt", {gnt_valid, gnt_data, gnt_core}, 3'b100);
        cyc; smp;
        chk("f_t2_iwait", iwait, 2'b11);
        cyc; ramstate = ACCESS; smp;
        chk("f_t3_iwait", iwait, 2'b10);
        chk("f_t3_ramREN", ramREN, 1);
        cyc; idle_inputs; smp;
        chk("f_t4_iwait", iwait, 2'b11);
        chk("f_t4_gnt_valid", gnt_valid, 0);

        // Two data writers (core 1 also asserts dREN: still a write).
        cyc;
        dWEN = 2'b11; dREN = 2'b10; ramstate = ACCESS;
        daddr = {32'h104, 32'h100}; dstore = {32'hB1, 32'hA0};
        for (int n = 0; n < 6; n++) begin
            if (n > 0) cyc;
            smp;
            chk("w_gnt_valid", gnt_valid, (n % 2 == 1) ? 1 : 0);
            if (n % 2 == 1) begin
                logic c;
                c = (n == 3);
                chk("w_gnt_core", gnt_core, c);
                chk("w_ramWEN", ramWEN, 1);
                chk("w_ramREN", ramREN, 0);
                chk("w_ramstore", ramstore, c ? 32'hB1 : 32'hA0);
                chk("w_ramaddr", ramaddr, c ? 32'h104 : 32'h100);
                chk("w_dwait", dwait, c ? 2'b01 : 2'b10);
            end
        end
        cyc; idle_inputs;
        cyc;

        // Starvation: data from core 1 forever plus a fetch from core 0.
        cyc; nRST = 1'b0;
        cyc; nRST = 1'b1;
        cyc;
        dREN = 2'b10; iREN = 2'b01; ramstate = ACCESS;
        daddr[63:32] = 32'h200; iaddr[31:0] = 32'h40;
        for (int n = 0; n < 12; n++) begin
            if (n > 0) cyc;
            smp;
            chk("s_gnt_valid", gnt_valid, (n % 2 == 1) ? 1 : 0);
            if (n % 2 == 1) begin
                chk("s_gnt_data", gnt_data, (n == 9) ? 0 : 1);
                if (n == 9) begin
                    chk("s_fetch_core", gnt_core, 0);
                    chk("s_fetch_addr", ramaddr, 32'h40);
                    chk("s_fetch_iwait", iwait, 2'b10);
                    chk("s_starve_clr", dut.starve, 0);
                end else begin
                    chk("s_data_core", gnt_core, 1);
                    chk("s_data_dwait", dwait, 2'b01);
                end
            end
            if (n == 8) chk("s_starve_sat", dut.starve, 8);
        end
        cyc; idle_inputs;
        cyc;

        // Data read withdrawn while the RAM is busy.
        cyc; dREN = 2'b01; daddr[31:0] = 32'h300; ramstate = BUSY; smp;
        chk("a_t0_gnt_valid", gnt_valid, 0);
        cyc; smp;
        chk("a_t1_gnt", {gnt_valid, gnt_data, gnt_core}, 3'b110);
        chk("a_t1_ramREN", ramREN, 1);
        chk("a_t1_ramaddr", ramaddr, 32'h300);
        chk("a_t1_dwait", dwait, 2'b11);
        cyc; dREN = 2'b00; smp;
        chk("a_t2_dwait", dwait, 2'b11);
        chk("a_t2_ramREN", ramREN, 0);
        cyc; smp;
        chk("a_t3_gnt_valid", gnt_valid, 0);
        chk("a_t3_dwait", dwait, 2'b11);

        // Reset while owning a busy RAM.
        cyc; dREN = 2'b01; ramstate = BUSY;
        cyc; smp;
        chk("r_own", gnt_valid, 1);
        chk("r_rr_d_pre", dut.rr_d, 1);
        chk("r_rr_i_pre", dut.rr_i, 1);
        cyc; nRST = 1'b0;
        cyc; smp;
        chk("r_state", dut.state, 0);
        chk("r_gnt_valid", gnt_valid, 0);
        chk("r_ramREN", ramREN, 0);
        chk("r_ramaddr", ramaddr, 0);
        chk("r_dwait", dwait, 2'b11);
        chk("r_iwait", iwait, 2'b11);
        chk("r_rr_d", dut.rr_d, 0);
        chk("r_rr_i", dut.rr_i, 0);
        cyc; nRST = 1'b1; idle_inputs;
        cyc;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
